// File: rtl/ac_match_collector.sv
// Aho-Corasick match collector: registers the automaton state, looks up accept/pattern-id
// and queues {position, pid} match records in a first-word-fall-through FIFO.
module ac_match_collector #(
    parameter int STATE_W    = 8,
    parameter int PID_W      = 4,
    parameter int POS_W      = 16,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8,
    // ROM image, entry i at bits [i*8 +: 8]: bit 7 = accept, bits [PID_W-1:0] = pattern id
    parameter logic [(2**STATE_W)*8-1:0] ACCEPT_ROM = '0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               INITIALIZE,
    input  logic               SYM_VALID,
    input  logic [STATE_W-1:0] NOW_STATE,
    input  logic               EN_MATCH,
    output logic [STATE_W-1:0] STATE_Q,
    output logic               M_VALID,
    input  logic               M_READY,
    output logic [POS_W-1:0]   M_POS,
    output logic [PID_W-1:0]   M_PID,
    output logic [CNT_W-1:0]   MATCH_CNT,
    output logic               OVERFLOW
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int REC_W = POS_W + PID_W;

    logic [STATE_W-1:0] state_q;
    logic [POS_W-1:0]   pos_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;
    logic [AW:0]        wr_ptr_q;
    logic [AW:0]        rd_ptr_q;
    logic [REC_W-1:0]   mem_q [FIFO_DEPTH];

    logic               clr;
    logic               rom_accept;
    logic [PID_W-1:0]   rom_pid;
    logic               hit;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    logic [REC_W-1:0]   head;

    assign clr        = !RST || INITIALIZE;
    assign rom_accept = ACCEPT_ROM[{NOW_STATE, 3'd7}];
    assign rom_pid    = ACCEPT_ROM[{NOW_STATE, 3'd0} +: PID_W];
    assign hit        = SYM_VALID && EN_MATCH && rom_accept;

    // Wrap bit distinguishes full from empty when the index bits are equal.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !clr && !empty && M_READY;
    assign push  = !clr && hit && (!full || pop);

    always_ff @(posedge CLK) begin
        if (clr) begin
            state_q  <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (SYM_VALID) begin
                state_q <= NOW_STATE;
                pos_q   <= pos_q + 1'b1;
            end
            if (hit && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (hit && full && !pop) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Record storage needs no reset: it is only observed through the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {pos_q, rom_pid};
        end
    end

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign STATE_Q   = state_q;
    assign M_VALID   = !empty;
    assign M_POS     = empty ? '0 : head[REC_W-1:PID_W];
    assign M_PID     = empty ? '0 : head[PID_W-1:0];
    assign MATCH_CNT = cnt_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_ac_match_collector.sv
// Bench for ac_match_collector: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the collector's behaviour.
module tb_ac_match_collector;

    localparam int DEPTH = 8;

    function automatic logic [2047:0] build_rom();
        logic [2047:0] img;
        logic [7:0]    e;
        img = '0;
        for (int i = 0; i < 256; i++) begin
            e = 8'h00;
            if (i == 5)
                e = 8'h83;
            else if (i % 3 == 0)
                e = {1'b1, 3'b000, 4'(i ^ (i >> 4))};
            else if (i % 7 == 0)
                e = {1'b0, 3'b000, 4'(i)};
            img[i*8 +: 8] = e;
        end
        return img;
    endfunction

    localparam logic [2047:0] ROM_IMG = build_rom();

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        INITIALIZE = 1'b0;
    logic        SYM_VALID = 1'b0;
    logic [7:0]  NOW_STATE = '0;
    logic        EN_MATCH = 1'b0;
    logic [7:0]  STATE_Q;
    logic        M_VALID;
    logic        M_READY = 1'b0;
    logic [15:0] M_POS;
    logic [3:0]  M_PID;
    logic [15:0] MATCH_CNT;
    logic        OVERFLOW;

    ac_match_collector #(
        .STATE_W(8), .PID_W(4), .POS_W(16), .CNT_W(16), .FIFO_DEPTH(DEPTH),
        .ACCEPT_ROM(ROM_IMG)
    ) dut (
        .CLK(CLK), .RST(RST), .INITIALIZE(INITIALIZE), .SYM_VALID(SYM_VALID),
        .NOW_STATE(NOW_STATE), .EN_MATCH(EN_MATCH), .STATE_Q(STATE_Q), .M_VALID(M_VALID),
        .M_READY(M_READY), .M_POS(M_POS), .M_PID(M_PID), .MATCH_CNT(MATCH_CNT),
        .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Reference model
    logic [7:0]  rom_m [256];
    logic [19:0] exp_q [$];
    logic [7:0]  m_state;
    logic [15:0] m_pos;
    logic [15:0] m_cnt;
    logic        m_ovf;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [19:0] hd;
        hd = (exp_q.size() > 0) ? exp_q[0] : 20'h0;
        chk("state_q",   32'(STATE_Q),   32'(m_state));
        chk("m_valid",   32'(M_VALID),   32'(exp_q.size() > 0));
        chk("m_pos",     32'(M_POS),     32'(hd[19:4]));
        chk("m_pid",     32'(M_PID),     32'(hd[3:0]));
        chk("match_cnt", 32'(MATCH_CNT), 32'(m_cnt));
        chk("overflow",  32'(OVERFLOW),  32'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model by the collector's rules, compare after the edge.
    task automatic step(input logic rst, input logic init, input logic sv, input logic [7:0] ns,
                        input logic em, input logic rdy, input logic do_chk);
        int  occ;
        bit  popped;
        bit  hit;
        RST = rst; INITIALIZE = init; SYM_VALID = sv; NOW_STATE = ns; EN_MATCH = em;
        M_READY = rdy;
        @(posedge CLK);
        if (!rst || init) begin
            exp_q.delete();
            m_state = 0; m_pos = 0; m_cnt = 0; m_ovf = 0;
        end else begin
            occ    = exp_q.size();
            popped = (occ > 0) && rdy;
            hit    = sv && em && rom_m[ns][7];
            if (popped) void'(exp_q.pop_front());
            if (hit) begin
                if (occ < DEPTH || popped) exp_q.push_back({m_pos, rom_m[ns][3:0]});
                else m_ovf = 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
            end
            if (sv) begin
                m_state = ns;
                m_pos   = m_pos + 1;
            end
        end
        #1;
        if (do_chk) check_all();
    endtask

    task automatic sym(input logic [7:0] ns, input logic em, input logic rdy);
        step(1'b1, 1'b0, 1'b1, ns, em, rdy, 1'b1);
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, rdy, 1'b1);
    endtask

    task automatic soft_clear();
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_m[i] = ROM_IMG[i*8 +: 8];
        m_state = 0; m_pos = 0; m_cnt = 0; m_ovf = 0;

        // Reset held for two cycles while symbols are presented
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1);
        chk("rst_state", 32'(STATE_Q), 0);
        chk("rst_cnt",   32'(MATCH_CNT), 0);
        chk("rst_valid", 32'(M_VALID), 0);
        chk("rst_ovf",   32'(OVERFLOW), 0);

        // Basic match: states 1,2,5,0 with only state 5 accepting and enabled
        sym(8'd1, 1'b1, 1'b0); chk("seq_s0", 32'(STATE_Q), 1);
        sym(8'd2, 1'b1, 1'b0); chk("seq_s1", 32'(STATE_Q), 2);
        sym(8'd5, 1'b1, 1'b0); chk("seq_s2", 32'(STATE_Q), 5);
        chk("basic_valid", 32'(M_VALID), 1);
        sym(8'd0, 1'b0, 1'b0); chk("seq_s3", 32'(STATE_Q), 0);
        chk("basic_pos", 32'(M_POS), 2);
        chk("basic_pid", 32'(M_PID), 3);
        chk("basic_cnt", 32'(MATCH_CNT), 1);
        idle(1'b1);
        chk("basic_drained", 32'(M_VALID), 0);

        // Ten hits with the consumer stalled: eight held, overflow on the ninth
        soft_clear();
        for (int i = 0; i < 10; i++) begin
            sym(8'd5, 1'b1, 1'b0);
            if (i == 7) chk("ovf_before", 32'(OVERFLOW), 0);
            if (i == 8) chk("ovf_at_9th", 32'(OVERFLOW), 1);
        end
        chk("full_cnt", 32'(MATCH_CNT), 10);
        for (int i = 0; i < 8; i++) begin
            chk("drain_pos", 32'(M_POS), 32'(i));
            idle(1'b1);
        end
        chk("drain_empty", 32'(M_VALID), 0);

        // Full FIFO, hit and pop in the same cycle
        soft_clear();
        for (int i = 0; i < 8; i++) sym(8'd5, 1'b1, 1'b0);
        sym(8'd5, 1'b1, 1'b1);
        chk("fullpop_ovf", 32'(OVERFLOW), 0);
        chk("fullpop_occ", 32'(exp_q.size()), 8);
        for (int i = 1; i <= 8; i++) begin
            chk("fullpop_order", 32'(M_POS), 32'(i));
            idle(1'b1);
        end
        chk("fullpop_empty", 32'(M_VALID), 0);

        // Position counter wrap
        soft_clear();
        for (int i = 0; i < 65535; i++) step(1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        check_all();
        sym(8'd5, 1'b1, 1'b0);
        sym(8'd5, 1'b1, 1'b0);
        chk("wrap_pos_hi", 32'(M_POS), 32'hFFFF);
        idle(1'b1);
        chk("wrap_pos_lo", 32'(M_POS), 0);
        idle(1'b1);

        // Soft clear with occupied FIFO, overflow set and a symbol presented
        soft_clear();
        for (int i = 0; i < 9; i++) sym(8'd5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("pre_init_ovf", 32'(OVERFLOW), 1);
        step(1'b1, 1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1);
        chk("init_valid", 32'(M_VALID), 0);
        chk("init_ovf",   32'(OVERFLOW), 0);
        chk("init_cnt",   32'(MATCH_CNT), 0);
        chk("init_state", 32'(STATE_Q), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 199) != 0, $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
